// File: rtl/mem_access_unit.sv
// Load/store initiator for the core's unified byte-addressed memory.
// Word-wide port; SB/SH use read-modify-write, sub-word loads are extended here.
module mem_access_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] address,
    output logic [31:0] writeData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memData
);

    // state | meaning
    // IDLE  | waiting for req
    // RD    | memRead issued; word captured on exit
    // WR    | memWrite issued with merged or full word
    // DONE  | completion pulse, err=0
    // ERR   | completion pulse, err=1, no memory traffic
    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, word_q, rdata_q;
    logic        illegal, misaligned, out_of_range;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext, merged;

    assign illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && we);
    assign misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                          ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign out_of_range = {addr[31:2], 2'b00} > 32'(MEM_BYTES - 4);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req) begin
                if (illegal || misaligned || out_of_range) state_nx = ERR;
                else if (we && funct3 == 3'b010)           state_nx = WR;
                else                                       state_nx = RD;
            end
            RD:      state_nx = we_q ? WR : DONE;
            WR:      state_nx = DONE;
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Load extraction works on the live memory word so rdata lands on the edge entering DONE.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = memData[7:0];
            2'd1:    byte_sel = memData[15:8];
            2'd2:    byte_sel = memData[23:16];
            default: byte_sel = memData[31:24];
        endcase
        half_sel = addr_q[1] ? memData[31:16] : memData[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = memData;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            word_q   <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                we_q     <= we;
                funct3_q <= funct3;
                addr_q   <= addr;
                wdata_q  <= wdata;
            end
            if (state == RD) begin
                word_q <= memData;
                if (!we_q) rdata_q <= load_ext;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE) || (state == ERR);
    assign err       = (state == ERR);
    assign memRead   = (state == RD);
    assign memWrite  = (state == WR);
    assign address   = {addr_q[31:2], 2'b00};
    assign writeData = merged;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory model plus an expected-result queue.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err, memRead, memWrite;
    logic [31:0] rdata, address, writeData, memData;

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .address(address), .writeData(writeData),
        .memRead(memRead), .memWrite(memWrite), .memData(memData)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] ai;
    assign ai      = {address[7:2], 2'b00};
    assign memData = {mem[ai + 8'd3], mem[ai + 8'd2], mem[ai + 8'd1], mem[ai]};

    always @(posedge clk) begin
        if (memWrite) begin
            mem[ai]        <= writeData[7:0];
            mem[ai + 8'd1] <= writeData[15:8];
            mem[ai + 8'd2] <= writeData[23:16];
            mem[ai + 8'd3] <= writeData[31:24];
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] wdata;
    } xact_t;

    xact_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = 32'd0;

    // Drives one request and records what the DUT did until done (or 10 cycles).
    task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, output xact_t o,
                           output logic addr_ok, output logic overlap);
        o = '0;
        addr_ok = 1'b1;
        overlap = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (memRead && o.rd_cyc == 0) o.rd_cyc = c;
            if (memWrite && o.wr_cyc == 0) begin
                o.wr_cyc = c;
                o.wdata  = writeData;
            end
            if ((memRead || memWrite) && address !== {a[31:2], 2'b00}) addr_ok = 1'b0;
            if (memRead && memWrite) overlap = 1'b1;
            if (done) begin
                o.lat   = c;
                o.err   = err;
                o.rdata = rdata;
                break;
            end
        end
    endtask

    localparam int NT = 11;
    localparam logic        T_W [NT] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    localparam logic [2:0]  T_F [NT] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000,
                                         3'b010, 3'b001, 3'b001, 3'b010, 3'b010};
    localparam logic [31:0] T_A [NT] = '{0, 6, 6, 6, 6, 129, 128, 130, 130, 252, 252};
    localparam logic [31:0] T_D [NT] = '{0, 0, 0, 0, 0, 32'h123456AB, 0, 32'h0000BEEF,
                                         0, 32'hDEADBEEF, 0};
    localparam logic [31:0] T_R [NT] = '{32'h00400293, 32'hFFFFFFF0, 32'h000000F0,
                                         32'hFFFFFFF0, 32'h0000FFF0, 0, 32'h0000AB00,
                                         0, 32'hFFFFBEEF, 0, 32'hDEADBEEF};
    localparam int          T_L [NT] = '{2, 2, 2, 2, 2, 3, 2, 3, 2, 2, 2};
    localparam int          T_RC[NT] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    localparam int          T_WC[NT] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0};
    localparam logic [31:0] T_WD[NT] = '{0, 0, 0, 0, 0, 32'h0000AB00, 0, 32'hBEEFAB00,
                                         0, 32'hDEADBEEF, 0};

    localparam int NE = 5;
    localparam logic        E_W [NE] = '{1, 0, 0, 1, 0};
    localparam logic [2:0]  E_F [NE] = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b011};
    localparam logic [31:0] E_A [NE] = '{3, 130, 256, 0, 0};

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, memRead, memWrite} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, memRead, memWrite});
        end
        checks++;
        if (address !== 32'd0) begin
            errors++;
            $display("FAIL reset_address: got %h want 0", address);
        end
        checks++;
        if (writeData !== 32'd0) begin
            errors++;
            $display("FAIL reset_writeData: got %h want 0", writeData);
        end
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        model_rdata = 32'd0;
        reset = 1'b0;
    endtask

    task automatic test_loads_stores();
        xact_t o, e;
        logic  aok, ovl;
        for (int i = 0; i < NT; i++) begin
            e = '0;
            e.err    = 1'b0;
            e.rdata  = (T_W[i] == 1'b0) ? T_R[i] : model_rdata;
            e.lat    = T_L[i];
            e.rd_cyc = T_RC[i];
            e.wr_cyc = T_WC[i];
            e.wdata  = T_WD[i];
            sb.push_back(e);
            model_rdata = e.rdata;
            run_req(T_W[i], T_F[i], T_A[i], T_D[i], o, aok, ovl);
            e = sb.pop_front();
            checks++;
            if (o.lat !== e.lat) begin
                errors++;
                $display("FAIL ls%0d_latency: got %0d want %0d", i, o.lat, e.lat);
            end
            checks++;
            if (o.err !== e.err) begin
                errors++;
                $display("FAIL ls%0d_err: got %b want %b", i, o.err, e.err);
            end
            checks++;
            if (o.rdata !== e.rdata) begin
                errors++;
                $display("FAIL ls%0d_rdata: got %h want %h", i, o.rdata, e.rdata);
            end
            checks++;
            if (o.rd_cyc !== e.rd_cyc || o.wr_cyc !== e.wr_cyc) begin
                errors++;
                $display("FAIL ls%0d_rw_cycle: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                         i, o.rd_cyc, o.wr_cyc, e.rd_cyc, e.wr_cyc);
            end
            if (e.wr_cyc != 0) begin
                checks++;
                if (o.wdata !== e.wdata) begin
                    errors++;
                    $display("FAIL ls%0d_writeData: got %h want %h", i, o.wdata, e.wdata);
                end
            end
            checks++;
            if (aok !== 1'b1 || ovl !== 1'b0) begin
                errors++;
                $display("FAIL ls%0d_address_overlap: got addr_ok=%b overlap=%b want 1 0",
                         i, aok, ovl);
            end
        end
    endtask

    task automatic test_errors();
        xact_t o, e;
        logic  aok, ovl;
        for (int i = 0; i < NE; i++) begin
            e = '0;
            e.err   = 1'b1;
            e.rdata = model_rdata;
            e.lat   = 1;
            sb.push_back(e);
            run_req(E_W[i], E_F[i], E_A[i], 32'hA5A5A5A5, o, aok, ovl);
            e = sb.pop_front();
            checks++;
            if (o.lat !== e.lat || o.err !== e.err) begin
                errors++;
                $display("FAIL err%0d_done: got lat=%0d err=%b want lat=%0d err=%b",
                         i, o.lat, o.err, e.lat, e.err);
            end
            checks++;
            if (o.rd_cyc !== 0 || o.wr_cyc !== 0) begin
                errors++;
                $display("FAIL err%0d_no_mem: got rd=%0d wr=%0d want 0 0", i, o.rd_cyc, o.wr_cyc);
            end
            checks++;
            if (o.rdata !== e.rdata) begin
                errors++;
                $display("FAIL err%0d_rdata: got %h want %h", i, o.rdata, e.rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:1] mw, dn, bz;
        xact_t o, e;
        logic  aok, ovl;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'd252; wdata = 32'h11223344;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            mw[c] = memWrite;
            dn[c] = done;
            bz[c] = busy;
            if (c == 4) req = 1'b0;
        end
        checks++;
        if (mw !== 5'b01001) begin
            errors++;
            $display("FAIL hold_memWrite: got %b want 01001", mw);
        end
        checks++;
        if (dn !== 5'b10010) begin
            errors++;
            $display("FAIL hold_done: got %b want 10010", dn);
        end
        checks++;
        if (bz !== 5'b11011) begin
            errors++;
            $display("FAIL hold_busy: got %b want 11011", bz);
        end
        e = '0;
        e.rdata = 32'h11223344;
        e.lat = 2;
        e.rd_cyc = 1;
        sb.push_back(e);
        model_rdata = e.rdata;
        run_req(1'b0, 3'b010, 32'd252, 32'd0, o, aok, ovl);
        e = sb.pop_front();
        checks++;
        if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: got lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=0",
                     o.lat, o.rdata, o.err, e.lat, e.rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic  seen_wr, seen_done;
        xact_t o, e;
        logic  aok, ovl;
        seen_wr = 1'b0;
        seen_done = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'd134; wdata = 32'h00005555;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (memRead !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_rd: got memRead=%b want 1", memRead);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, memRead, memWrite} !== 5'b0 || address !== 0 || rdata !== 0) begin
            errors++;
            $display("FAIL midrst_outputs: got ctrl=%b address=%h rdata=%h want 0",
                     {busy, done, err, memRead, memWrite}, address, rdata);
        end
        model_rdata = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (memWrite) seen_wr = 1'b1;
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (seen_wr !== 1'b0 || seen_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: got memWrite=%b done=%b want 0 0", seen_wr, seen_done);
        end
        e = '0;
        e.rdata = 32'h00400293;
        e.lat = 2;
        sb.push_back(e);
        model_rdata = e.rdata;
        run_req(1'b0, 3'b010, 32'd0, 32'd0, o, aok, ovl);
        e = sb.pop_front();
        checks++;
        if (o.lat !== e.lat || o.rdata !== e.rdata || o.err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_accept: got lat=%0d rdata=%h err=%b want lat=%0d rdata=%h err=0",
                     o.lat, o.rdata, o.err, e.lat, e.rdata);
        end
        run_req(1'b0, 3'b010, 32'd132, 32'd0, o, aok, ovl);
        checks++;
        if (o.rdata !== 32'd0) begin
            errors++;
            $display("FAIL midrst_no_write: got word132=%h want 0", o.rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[3], mem[2], mem[1], mem[0]} = 32'h00400293;
        mem[6] = 8'hF0;
        mem[7] = 8'hFF;
        test_reset();
        test_loads_stores();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
